// File: rtl/apb_master_if.sv
// Host request/response channel plus APB bus between apb_master and the
// slave-select decoder/mux.
interface apb_master_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pready;
  logic [DATA_W-1:0] Prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Pready, Prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Pready, Prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-channel APB requester: host request -> SETUP/ACCESS -> one response.
// Define APB_MASTER_TIMEOUT_EN to enable the ACCESS wait-state timeout.
module apb_master #(
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         Pclk,
  input  logic         Preset,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic              psel, pen, pwr, rvld;
  logic [ADDR_W-1:0] padr;
  logic [DATA_W-1:0] pwd, rdat;
  logic              abort;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES out of range 2..255");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wcnt;
  logic       rto;
  assign abort = (wcnt == WCNT_LAST);

  // Wait counter: cleared entering ACCESS, counts ACCESS edges with Pready low.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      wcnt <= '0;
      rto  <= 1'b0;
    end else begin
      if (state == SETUP) wcnt <= '0;
      else if (state == ACCESS && !bus.Pready) wcnt <= wcnt + 8'd1;
      if (state == ACCESS && (bus.Pready || abort)) rto <= !bus.Pready;
    end
  end
  assign bus.rsp_timeout = rto;
`else
  assign abort           = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state <= IDLE;
      psel  <= 1'b0;
      pen   <= 1'b0;
      pwr   <= 1'b0;
      padr  <= '0;
      pwd   <= '0;
      rvld  <= 1'b0;
      rdat  <= '0;
    end else begin
      rvld <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          pwr   <= bus.req_write;
          padr  <= bus.req_addr;
          pwd   <= bus.req_write ? bus.req_wdata : '0;
          psel  <= 1'b1;
          pen   <= 1'b0;
          state <= SETUP;
        end
        SETUP: begin
          pen   <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (bus.Pready || abort) begin
          // Pready wins on the abort edge: the transfer completes normally.
          psel  <= 1'b0;
          pen   <= 1'b0;
          rvld  <= 1'b1;
          rdat  <= (bus.Pready && !pwr) ? bus.Prdata : '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.Pselx     = psel;
  assign bus.Penable   = pen;
  assign bus.Pwrite    = pwr;
  assign bus.Paddr     = padr;
  assign bus.Pwdata    = pwd;
  assign bus.rsp_valid = rvld;
  assign bus.rsp_rdata = rdat;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; timeout steps follow APB_MASTER_TIMEOUT_EN.
module tb_apb_master;
  logic Pclk = 1'b0;
  logic Preset;
  int   vectors = 0;
  int   fails   = 0;
  int   seen;

  apb_master_if #(.ADDR_W(3), .DATA_W(16)) bus ();

  apb_master #(.ADDR_W(3), .DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
    .Pclk  (Pclk),
    .Preset(Preset),
    .bus   (bus)
  );

  always #5 Pclk = ~Pclk;

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Preset        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.Pready    = 1'b0;
    bus.Prdata    = '0;
    tick();
    tick();
    chk("rst req_ready", bus.req_ready, 1);
    chk("rst Pselx", bus.Pselx, 0);
    chk("rst Penable", bus.Penable, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst Paddr", bus.Paddr, 0);
    chk("rst Pwdata", bus.Pwdata, 0);
    chk("rst rsp_timeout", bus.rsp_timeout, 0);
    Preset = 1'b0;
    tick();

    // Zero-wait write
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'b010;
    bus.req_wdata = 16'hA5A5; bus.Pready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("wr c1 Pselx", bus.Pselx, 1);
    chk("wr c1 Penable", bus.Penable, 0);
    chk("wr c1 Paddr", bus.Paddr, 3'b010);
    chk("wr c1 Pwdata", bus.Pwdata, 16'hA5A5);
    chk("wr c1 Pwrite", bus.Pwrite, 1);
    chk("wr c1 req_ready", bus.req_ready, 0);
    tick();
    chk("wr c2 Pselx", bus.Pselx, 1);
    chk("wr c2 Penable", bus.Penable, 1);
    chk("wr c2 Paddr", bus.Paddr, 3'b010);
    chk("wr c2 Pwdata", bus.Pwdata, 16'hA5A5);
    chk("wr c2 rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("wr c3 rsp_valid", bus.rsp_valid, 1);
    chk("wr c3 rsp_timeout", bus.rsp_timeout, 0);
    chk("wr c3 rsp_rdata", bus.rsp_rdata, 0);
    chk("wr c3 Pselx", bus.Pselx, 0);
    chk("wr c3 Penable", bus.Penable, 0);
    chk("wr c3 req_ready", bus.req_ready, 1);
    chk("wr c3 Paddr hold", bus.Paddr, 3'b010);
    tick();
    chk("wr c4 rsp_valid", bus.rsp_valid, 0);

    // Read with three wait states
    bus.Pready = 1'b0; bus.Prdata = 16'hDEAD;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'b110;
    bus.req_wdata = 16'hFFFF;
    tick();
    bus.req_valid = 1'b0;
    chk("rd setup Pselx", bus.Pselx, 1);
    chk("rd setup Pwdata", bus.Pwdata, 0);
    chk("rd setup Pwrite", bus.Pwrite, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rd access Penable", bus.Penable, 1);
      chk("rd access Paddr", bus.Paddr, 3'b110);
      chk("rd access rsp_valid", bus.rsp_valid, 0);
      if (i == 3) begin
        bus.Pready = 1'b1; bus.Prdata = 16'h1234;
      end
      tick();
    end
    chk("rd rsp_valid", bus.rsp_valid, 1);
    chk("rd rsp_rdata", bus.rsp_rdata, 16'h1234);
    chk("rd rsp_timeout", bus.rsp_timeout, 0);
    chk("rd Pselx low", bus.Pselx, 0);
    bus.Prdata = 16'h0000;
    tick();
    chk("rd rsp_valid drop", bus.rsp_valid, 0);
    chk("rd rsp_rdata hold", bus.rsp_rdata, 16'h1234);

    // Back-to-back reads with req_valid held high
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.Pready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bus.req_addr = t[0] ? 3'b101 : 3'b001;
      bus.Prdata   = 16'h0100 + 16'(t);
      tick();
      chk("b2b setup Pselx", bus.Pselx, 1);
      chk("b2b setup Paddr", bus.Paddr, t[0] ? 3'b101 : 3'b001);
      chk("b2b setup rsp_valid", bus.rsp_valid, 0);
      tick();
      chk("b2b access Penable", bus.Penable, 1);
      chk("b2b access rsp_valid", bus.rsp_valid, 0);
      tick();
      chk("b2b rsp_valid", bus.rsp_valid, 1);
      chk("b2b rsp_rdata", bus.rsp_rdata, 32'h0100 + t);
      chk("b2b Pselx gap", bus.Pselx, 0);
      chk("b2b req_ready", bus.req_ready, 1);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b tail rsp_valid", bus.rsp_valid, 0);
    chk("b2b tail Pselx", bus.Pselx, 0);

    // Slave that never becomes ready
    bus.Pready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'b011;
    tick();
    bus.req_valid = 1'b0;
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to access Penable", bus.Penable, 1);
      chk("to access rsp_valid", bus.rsp_valid, 0);
      tick();
    end
    chk("to rsp_valid", bus.rsp_valid, 1);
    chk("to rsp_timeout", bus.rsp_timeout, 1);
    chk("to rsp_rdata", bus.rsp_rdata, 0);
    chk("to Pselx", bus.Pselx, 0);
    tick();
    chk("to hold rsp_timeout", bus.rsp_timeout, 1);

    // Pready rises on the last permitted ACCESS cycle
    bus.req_valid = 1'b1; bus.req_addr = 3'b111;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("late access Penable", bus.Penable, 1);
      chk("late access rsp_valid", bus.rsp_valid, 0);
      if (i == 3) begin
        bus.Pready = 1'b1; bus.Prdata = 16'hBEEF;
      end
      tick();
    end
    chk("late rsp_valid", bus.rsp_valid, 1);
    chk("late rsp_timeout", bus.rsp_timeout, 0);
    chk("late rsp_rdata", bus.rsp_rdata, 16'hBEEF);
    bus.Pready = 1'b0;
    tick();
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rsp_valid) seen++;
      tick();
    end
    chk("hang rsp_valid count", seen, 0);
    chk("hang Pselx", bus.Pselx, 1);
    chk("hang Penable", bus.Penable, 1);
    chk("hang rsp_timeout", bus.rsp_timeout, 0);
    Preset = 1'b1;
    tick();
    Preset = 1'b0;
    tick();
    chk("hang recover req_ready", bus.req_ready, 1);
`endif

    // Reset in the middle of a read ACCESS
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'b100;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rstmid access Penable", bus.Penable, 1);
    Preset = 1'b1; bus.Pready = 1'b1; bus.Prdata = 16'h7777;
    tick();
    Preset = 1'b0;
    chk("rstmid Pselx", bus.Pselx, 0);
    chk("rstmid Penable", bus.Penable, 0);
    chk("rstmid req_ready", bus.req_ready, 1);
    chk("rstmid rsp_valid", bus.rsp_valid, 0);
    chk("rstmid Paddr", bus.Paddr, 0);
    chk("rstmid rsp_rdata", bus.rsp_rdata, 0);
    tick();
    chk("rstmid next rsp_valid", bus.rsp_valid, 0);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'b001;
    bus.req_wdata = 16'h5A5A;
    tick();
    bus.req_valid = 1'b0;
    chk("post Pselx", bus.Pselx, 1);
    chk("post Pwdata", bus.Pwdata, 16'h5A5A);
    tick();
    chk("post Penable", bus.Penable, 1);
    tick();
    chk("post rsp_valid", bus.rsp_valid, 1);
    chk("post rsp_timeout", bus.rsp_timeout, 0);
    chk("post rsp_rdata", bus.rsp_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

Single-channel APB requester that converts host read/write requests into APB SETUP/ACCESS sequences driving the slave-select decoder/mux stage. Drives `Pselx`, `Penable`, `Pwrite`, `Paddr` and `Pwdata` toward the decoder. Consumes the already-muxed `Pready` and `Prdata` back from it. Returns one response per request to the host, with an optional wait-state timeout.

## Interface
Parameters:
- `ADDR_W`, 3: APB address width; matches the decoder's 3-bit `Paddr`.
- `DATA_W`, 16: read/write data width.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles before abort. Legal range 2..255. Used only with `APB_MASTER_TIMEOUT_EN`.

Ports:
- `Pclk` in 1: single clock; all logic is rising-edge.
- `Preset` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request present.
- `req_ready` out 1: request accepted on an edge where `req_valid & req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: transfer address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: read data; 0 for writes and aborts.
- `rsp_timeout` out 1: qualifies `rsp_valid`; 1 = aborted by timeout.
- `Pselx` out 1: APB select to the decoder.
- `Penable` out 1: APB enable.
- `Pwrite` out 1: APB direction.
- `Paddr` out ADDR_W: APB address.
- `Pwdata` out DATA_W: APB write data.
- `Pready` in 1: muxed slave ready.
- `Prdata` in DATA_W: muxed slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered, except that `req_ready = (state == IDLE)`.
- Reset: state IDLE. All outputs 0, except `req_ready` = 1.
- IDLE:
  - On `req_valid` high: capture `req_write`, `req_addr` and `req_wdata` into `Pwrite`, `Paddr` and `Pwdata`.
  - For a read, `Pwdata` is loaded with 0.
  - Next state is SETUP.
- SETUP: `Pselx`=1, `Penable`=0. Unconditionally go to ACCESS.
- ACCESS:
  - `Pselx`=1, `Penable`=1.
  - If `Pready`=1 at the edge: go to IDLE and assert `rsp_valid`=1 with `rsp_timeout`=0. `rsp_rdata` = `Prdata` for a read, 0 for a write.
  - If `Pready`=0: remain in ACCESS.
- Outside SETUP/ACCESS: `Pselx`=`Penable`=0. `Paddr`, `Pwrite` and `Pwdata` hold their last values.
- `Paddr`, `Pwrite` and `Pwdata` are stable from SETUP through the end of ACCESS.
- `rsp_rdata` and `rsp_timeout` hold their values until the next `rsp_valid`.
- Host inputs are ignored outside IDLE. No queuing: one outstanding transfer at a time.
- Synchronous reset in any state aborts the transfer:
  - next cycle is IDLE with all outputs at reset values;
  - no `rsp_valid` is issued for the aborted transfer.

## Timing
- Accept edge (edge 0): SETUP is visible in cycle 1 and ACCESS in cycle 2.
- Zero-wait completion: `Pready`=1 at the end of cycle 2 gives `rsp_valid` in cycle 3, which is also IDLE with `req_ready`=1.
- Minimum period: 3 cycles per transfer (SETUP, ACCESS, IDLE).
- Each `Pready`=0 ACCESS cycle adds exactly one cycle of latency.
- `Prdata` is sampled only on the edge where ACCESS and `Pready`=1.
- `rsp_valid` is high for exactly one cycle per completed transfer.

## Configuration
- Macro `APB_MASTER_TIMEOUT_EN` defined:
  - A wait counter clears on ACCESS entry and increments on each ACCESS edge with `Pready`=0.
  - When the counter reaches `TIMEOUT_CYCLES-1` with `Pready`=0, the transfer aborts: go to IDLE with `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - Net effect: ACCESS lasts at most `TIMEOUT_CYCLES` cycles.
  - If `Pready`=1 on the abort edge, the transfer completes normally.
- Macro undefined:
  - No counter is present and `rsp_timeout` is tied to 0.
  - ACCESS waits indefinitely for `Pready`.

## Test plan
- Write `addr`=3'b010, `wdata`=16'hA5A5, `Pready`=1 constant -> `Pselx` high cycles 1–2, `Penable` high cycle 2 only, `Paddr`=3'b010 and `Pwdata`=16'hA5A5 during cycles 1–2, `rsp_valid` in cycle 3 with `rsp_timeout`=0.
- Read `addr`=3'b110, `Pready` low for 3 ACCESS cycles then high with `Prdata`=16'h1234 -> ACCESS lasts 4 cycles, `rsp_rdata`=16'h1234, `Pwdata`=0.
- `req_valid` held high for 4 reads to alternating addresses 3'b001/3'b101, `Pready`=1 -> 4 `rsp_valid` pulses, each 3 cycles apart; `Pselx` drops for exactly one cycle between transfers.
- Macro on, `TIMEOUT_CYCLES`=4, `Pready` held 0 -> ACCESS lasts exactly 4 cycles, then `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0. Macro off with the same stimulus -> still in ACCESS after 100 cycles, no `rsp_valid`.
- Macro on, `TIMEOUT_CYCLES`=4, `Pready` rises on the 4th ACCESS cycle with `Prdata`=16'hBEEF -> normal completion, `rsp_timeout`=0, `rsp_rdata`=16'hBEEF.
- `Preset` asserted for one cycle during ACCESS of a read -> next cycle `Pselx`=`Penable`=0, `req_ready`=1, no `rsp_valid`; a subsequent request completes normally.
